// File: rtl/trigger_sequencer_if.sv
// trigger_sequencer_if: byte-wide serial register bus shared by the trigger-path modules
interface trigger_sequencer_if;
    logic [7:0]  reg_cmd;
    logic [15:0] reg_bytecount;
    logic [7:0]  reg_data_in;
    logic [7:0]  reg_data_out;
    logic        reg_read;
    logic        reg_write;
    modport master (output reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write, input reg_data_out);
    modport slave  (input reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write, output reg_data_out);
endinterface

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: armed trigger_in edge -> delay -> pulse train; TRIG_SEQ_AUTO_REARM_EN enables CTRL bit1 auto re-arm
module trigger_sequencer #(
    parameter logic [7:0] CMD_DELAY  = 8'h20,
    parameter logic [7:0] CMD_WIDTH  = 8'h21,
    parameter logic [7:0] CMD_GAP    = 8'h22,
    parameter logic [7:0] CMD_COUNT  = 8'h23,
    parameter logic [7:0] CMD_CTRL   = 8'h24,
    parameter logic [7:0] CMD_STATUS = 8'h25
) (
    input  logic                clk_usb,
    input  logic                reset,
    input  logic                trigger_in,
    trigger_sequencer_if.slave  bus,
    output logic                trigger,
    output logic                busy
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

`ifdef TRIG_SEQ_AUTO_REARM_EN
    localparam logic [1:0] CTRL_MASK = 2'b11;
`else
    localparam logic [1:0] CTRL_MASK = 2'b01;
`endif

    state_t          state, state_n;
    logic [3:0][7:0] delay_r;
    logic [1:0][7:0] width_r;
    logic [3:0][7:0] gap_r;
    logic [7:0]      count_r;
    logic [1:0]      ctrl;
    logic [31:0]     cnt, cnt_n;
    logic [15:0]     lat_w;
    logic [31:0]     lat_gap;
    logic [7:0]      lat_cnt;
    logic [7:0]      pulses, pulses_n;
    logic [15:0]     bc;
    logic [15:0]     width_ev;
    logic            trig_q, trig_n, latch, abort, cfg_wr;

    assign bc       = bus.reg_bytecount;
    assign busy     = state inside {S_DELAY, S_PULSE, S_GAP};
    assign cfg_wr   = bus.reg_write && !busy;
    assign abort    = bus.reg_write && bus.reg_cmd == CMD_CTRL && bc == 16'd0 && !bus.reg_data_in[0];
    assign width_ev = (width_r == '0) ? 16'd1 : width_r;

    // Config registers: byte-addressed writes, timing registers locked while a sequence runs
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            delay_r <= '0;
            width_r <= 16'd1;
            gap_r   <= '0;
            count_r <= 8'd1;
            ctrl    <= '0;
        end else begin
            if (cfg_wr && bus.reg_cmd == CMD_DELAY && bc < 16'd4) delay_r[bc[1:0]] <= bus.reg_data_in;
            if (cfg_wr && bus.reg_cmd == CMD_WIDTH && bc < 16'd2) width_r[bc[0]] <= bus.reg_data_in;
            if (cfg_wr && bus.reg_cmd == CMD_GAP && bc < 16'd4) gap_r[bc[1:0]] <= bus.reg_data_in;
            if (cfg_wr && bus.reg_cmd == CMD_COUNT && bc == 16'd0) count_r <= bus.reg_data_in;
            if (bus.reg_write && bus.reg_cmd == CMD_CTRL && bc == 16'd0) ctrl <= bus.reg_data_in[1:0] & CTRL_MASK;
            if (state == S_DONE && !ctrl[1]) ctrl[0] <= 1'b0;
        end
    end

    // Sequencer state, counters and the timing values latched at the trigger event
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            state   <= S_IDLE;
            trigger <= 1'b0;
            cnt     <= '0;
            pulses  <= '0;
            trig_q  <= 1'b0;
            lat_w   <= 16'd1;
            lat_gap <= '0;
            lat_cnt <= 8'd1;
        end else begin
            state   <= state_n;
            trigger <= trig_n;
            cnt     <= cnt_n;
            pulses  <= pulses_n;
            trig_q  <= trigger_in;
            if (latch) begin
                lat_w   <= width_ev;
                lat_gap <= gap_r;
                lat_cnt <= (count_r == 8'd0) ? 8'd1 : count_r;
            end
        end
    end

    // Next state: cnt holds remaining cycles minus one of the current phase
    always_comb begin
        state_n  = state;
        trig_n   = trigger;
        cnt_n    = cnt;
        pulses_n = pulses;
        latch    = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl[0]) begin
                    state_n  = S_ARMED;
                    pulses_n = '0;
                end
            end
            S_ARMED: begin
                if (trigger_in && !trig_q) begin
                    latch = 1'b1;
                    if (delay_r == '0) begin
                        state_n = S_PULSE;
                        trig_n  = 1'b1;
                        cnt_n   = {16'd0, width_ev - 16'd1};
                    end else begin
                        state_n = S_DELAY;
                        cnt_n   = delay_r - 32'd1;
                    end
                end
            end
            S_DELAY, S_GAP: begin
                if (cnt == '0) begin
                    state_n = S_PULSE;
                    trig_n  = 1'b1;
                    cnt_n   = {16'd0, lat_w - 16'd1};
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    pulses_n = pulses + 8'd1;
                    if (pulses_n == lat_cnt) begin
                        state_n = S_DONE;
                        trig_n  = 1'b0;
                    end else if (lat_gap == '0) begin
                        cnt_n = {16'd0, lat_w - 16'd1};
                    end else begin
                        state_n = S_GAP;
                        trig_n  = 1'b0;
                        cnt_n   = lat_gap - 32'd1;
                    end
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            S_DONE: begin
                state_n  = ctrl[1] ? S_ARMED : S_IDLE;
                pulses_n = ctrl[1] ? 8'd0 : pulses;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort) begin
            state_n = S_IDLE;
            trig_n  = 1'b0;
        end
    end

    // Combinational read mux; zero when not reading or out of range
    always_comb begin
        bus.reg_data_out = 8'h00;
        if (bus.reg_read) begin
            case (bus.reg_cmd)
                CMD_DELAY:  bus.reg_data_out = (bc < 16'd4) ? delay_r[bc[1:0]] : 8'h00;
                CMD_WIDTH:  bus.reg_data_out = (bc < 16'd2) ? width_r[bc[0]] : 8'h00;
                CMD_GAP:    bus.reg_data_out = (bc < 16'd4) ? gap_r[bc[1:0]] : 8'h00;
                CMD_COUNT:  bus.reg_data_out = (bc == 16'd0) ? count_r : 8'h00;
                CMD_CTRL:   bus.reg_data_out = (bc == 16'd0) ? {6'd0, ctrl} : 8'h00;
                CMD_STATUS: bus.reg_data_out = (bc == 16'd0) ? {5'd0, state} : (bc == 16'd1) ? pulses : 8'h00;
                default:    bus.reg_data_out = 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: directed stimulus with scoreboard queues checked by a negedge monitor
module tb_trigger_sequencer;
    localparam logic [7:0] C_DELAY  = 8'h20;
    localparam logic [7:0] C_WIDTH  = 8'h21;
    localparam logic [7:0] C_GAP    = 8'h22;
    localparam logic [7:0] C_COUNT  = 8'h23;
    localparam logic [7:0] C_CTRL   = 8'h24;
    localparam logic [7:0] C_STATUS = 8'h25;

    logic clk_usb = 1'b0;
    logic reset = 1'b1;
    logic trigger_in = 1'b0;
    logic trigger, busy;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    trigger_sequencer_if bus();

    trigger_sequencer dut (
        .clk_usb(clk_usb),
        .reset(reset),
        .trigger_in(trigger_in),
        .bus(bus),
        .trigger(trigger),
        .busy(busy)
    );

    always #5 clk_usb = ~clk_usb;

    always @(posedge clk_usb) cyc <= cyc + 1;

    typedef struct {
        int start;
        int len;
    } pulse_t;

    pulse_t     pulse_q[$];
    int         busy_q[$];
    logic [7:0] rd_q[$];
    string      rd_name_q[$];

    logic       prev_trig = 1'b0;
    logic       prev_busy = 1'b0;
    int         rise_c = 0;
    logic [7:0] exp_v;
    string      nm;
    pulse_t     ep;
    int         eb;

    // Monitor: compares each read, each completed trigger pulse and each busy fall against the queues
    always @(negedge clk_usb) begin
        if (bus.reg_read) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL read_unexpected: got %h, required no read", bus.reg_data_out);
            end else begin
                exp_v = rd_q.pop_front();
                nm = rd_name_q.pop_front();
                if (bus.reg_data_out !== exp_v) begin
                    bad++;
                    $display("FAIL %s: got %h, required %h", nm, bus.reg_data_out, exp_v);
                end
            end
        end
        if (trigger && !prev_trig) rise_c = cyc;
        if (!trigger && prev_trig) begin
            total++;
            if (pulse_q.size() == 0) begin
                bad++;
                $display("FAIL pulse_unexpected: got start=%0d len=%0d, required none", rise_c, cyc - rise_c);
            end else begin
                ep = pulse_q.pop_front();
                if (rise_c != ep.start || cyc - rise_c != ep.len) begin
                    bad++;
                    $display("FAIL pulse: got start=%0d len=%0d, required start=%0d len=%0d", rise_c, cyc - rise_c, ep.start, ep.len);
                end
            end
        end
        if (!busy && prev_busy) begin
            total++;
            if (busy_q.size() == 0) begin
                bad++;
                $display("FAIL busy_unexpected: got fall at %0d, required none", cyc);
            end else begin
                eb = busy_q.pop_front();
                if (cyc != eb) begin
                    bad++;
                    $display("FAIL busy_fall: got %0d, required %0d", cyc, eb);
                end
            end
        end
        prev_trig = trigger;
        prev_busy = busy;
    end

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk_usb);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] c, input int b, input logic [7:0] d);
        bus.reg_cmd = c;
        bus.reg_bytecount = 16'(b);
        bus.reg_data_in = d;
        bus.reg_write = 1'b1;
        tick();
        bus.reg_write = 1'b0;
    endtask

    task automatic wr_n(input logic [7:0] c, input logic [31:0] v, input int nb);
        for (int i = 0; i < nb; i++) wr(c, i, v[8*i +: 8]);
    endtask

    task automatic rd(input logic [7:0] c, input int b, input logic [7:0] e, input string name);
        bus.reg_cmd = c;
        bus.reg_bytecount = 16'(b);
        bus.reg_read = 1'b1;
        rd_q.push_back(e);
        rd_name_q.push_back(name);
        tick();
        bus.reg_read = 1'b0;
    endtask

    task automatic fire(output int n);
        n = cyc + 1;
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
    endtask

    task automatic exp_pulse(input int s, input int l);
        pulse_t p;
        p.start = s;
        p.len = l;
        pulse_q.push_back(p);
    endtask

    task automatic cfg(input logic [31:0] d, input logic [31:0] w, input logic [31:0] g, input logic [31:0] c);
        wr_n(C_DELAY, d, 4);
        wr_n(C_WIDTH, w, 2);
        wr_n(C_GAP, g, 4);
        wr_n(C_COUNT, c, 1);
    endtask

    task automatic arm();
        wr(C_CTRL, 0, 8'h01);
        tick();
    endtask

    int n, m, r;

    initial begin
        bus.reg_cmd = '0;
        bus.reg_bytecount = '0;
        bus.reg_data_in = '0;
        bus.reg_read = 1'b0;
        bus.reg_write = 1'b0;
        tick(3);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) rd(C_DELAY, i, 8'h00, "rst_delay");
        rd(C_WIDTH, 0, 8'h01, "rst_width0");
        rd(C_WIDTH, 1, 8'h00, "rst_width1");
        rd(C_GAP, 0, 8'h00, "rst_gap");
        rd(C_COUNT, 0, 8'h01, "rst_count");
        rd(C_CTRL, 0, 8'h00, "rst_ctrl");
        rd(C_STATUS, 0, 8'h00, "rst_status0");
        rd(C_STATUS, 1, 8'h00, "rst_status1");
        rd(C_DELAY, 4, 8'h00, "delay_oob");
        rd(8'h30, 0, 8'h00, "unknown_cmd");

        wr_n(C_DELAY, 32'h12345678, 4);
        rd(C_DELAY, 0, 8'h78, "delay_b0");
        rd(C_DELAY, 1, 8'h56, "delay_b1");
        rd(C_DELAY, 2, 8'h34, "delay_b2");
        rd(C_DELAY, 3, 8'h12, "delay_b3");

        cfg(5, 3, 0, 1);
        arm();
        rd(C_STATUS, 0, 8'h01, "armed_state");
        fire(n);
        exp_pulse(n + 5, 3);
        busy_q.push_back(n + 8);
        tick();
        fire(m);
        tick(12);
        rd(C_STATUS, 0, 8'h00, "t2_state");
        rd(C_STATUS, 1, 8'h01, "t2_pulses");
        rd(C_CTRL, 0, 8'h00, "t2_ctrl");

        cfg(0, 2, 4, 3);
        arm();
        fire(n);
        exp_pulse(n, 2);
        exp_pulse(n + 6, 2);
        exp_pulse(n + 12, 2);
        busy_q.push_back(n + 14);
        tick(20);
        rd(C_STATUS, 1, 8'h03, "t3_pulses");
        rd(C_STATUS, 0, 8'h00, "t3_state");

        cfg(1, 2, 0, 2);
        arm();
        fire(n);
        exp_pulse(n + 1, 4);
        busy_q.push_back(n + 5);
        tick(10);
        rd(C_STATUS, 1, 8'h02, "gap0_pulses");

        cfg(0, 0, 0, 0);
        arm();
        fire(n);
        exp_pulse(n, 1);
        busy_q.push_back(n + 1);
        tick(6);
        rd(C_STATUS, 1, 8'h01, "w0c0_pulses");
        rd(C_WIDTH, 0, 8'h00, "w0_readback");

        cfg(100, 1, 0, 1);
        arm();
        fire(n);
        tick(9);
        busy_q.push_back(cyc + 1);
        wr(C_CTRL, 0, 8'h00);
        rd(C_STATUS, 0, 8'h00, "abort_state");
        fire(m);
        tick(110);
        rd(C_STATUS, 1, 8'h00, "abort_pulses");

        cfg(0, 4, 0, 1);
        arm();
        fire(n);
        exp_pulse(n, 4);
        busy_q.push_back(n + 4);
        wr(C_WIDTH, 0, 8'd50);
        wr(C_COUNT, 0, 8'd7);
        tick(6);
        rd(C_WIDTH, 0, 8'h04, "width_locked");
        rd(C_COUNT, 0, 8'h01, "count_locked");

        cfg(0, 10, 0, 1);
        arm();
        fire(n);
        tick(2);
        r = cyc + 1;
        exp_pulse(n, r - n);
        busy_q.push_back(r);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(C_WIDTH, 0, 8'h01, "midrst_width");
        rd(C_CTRL, 0, 8'h00, "midrst_ctrl");
        rd(C_STATUS, 0, 8'h00, "midrst_state");

        cfg(2, 1, 0, 1);
        wr(C_CTRL, 0, 8'h03);
        tick();
        fire(n);
        exp_pulse(n + 2, 1);
        busy_q.push_back(n + 3);
        tick(5);
`ifdef TRIG_SEQ_AUTO_REARM_EN
        rd(C_STATUS, 0, 8'h01, "rearm_state");
        rd(C_CTRL, 0, 8'h03, "rearm_ctrl");
        fire(m);
        exp_pulse(m + 2, 1);
        busy_q.push_back(m + 3);
        tick(6);
        rd(C_STATUS, 1, 8'h00, "rearm_pulses");
        wr(C_CTRL, 0, 8'h00);
        tick();
        rd(C_STATUS, 0, 8'h00, "rearm_stop");
`else
        rd(C_STATUS, 0, 8'h00, "norearm_state");
        rd(C_CTRL, 0, 8'h00, "norearm_ctrl");
        fire(m);
        tick(6);
        rd(C_STATUS, 1, 8'h01, "norearm_pulses");
`endif

        tick(2);
        total++;
        if (pulse_q.size() != 0) begin
            bad++;
            $display("FAIL pulse_drain: got %0d pending, required 0", pulse_q.size());
        end
        total++;
        if (busy_q.size() != 0) begin
            bad++;
            $display("FAIL busy_drain: got %0d pending, required 0", busy_q.size());
        end
        total++;
        if (rd_q.size() != 0) begin
            bad++;
            $display("FAIL read_drain: got %0d pending, required 0", rd_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
